// File: rtl/axi_arb_pkg.sv
// Shared types and AXI field widths for the two-requester AXI write arbiter.
package axi_arb_pkg;

   localparam int unsigned LenW   = 8;
   localparam int unsigned SizeW  = 3;
   localparam int unsigned BurstW = 2;
   localparam int unsigned RespW  = 2;

   localparam logic [RespW-1:0] RespOkay   = 2'b00;
   localparam logic [RespW-1:0] RespSlverr = 2'b10;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StAddr = 2'd1,
      StData = 2'd2,
      StResp = 2'd3
   } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; the pointer register is owned by the caller.
module rr_arbiter2 (
   input  logic [1:0] req_i,
   input  logic       ptr_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      if (req_i == 2'b11) begin
         gnt_o = ptr_i ? 2'b10 : 2'b01;
      end else begin
         gnt_o = req_i;
      end
   end

endmodule

// File: rtl/axi_write_arbiter.sv
// Shares one AXI write path between two requesters; a grant covers AW, all W beats and B.
module axi_write_arbiter
   import axi_arb_pkg::*;
#(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 64,
   parameter int unsigned SW = DW / 8
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [2*AW-1:0]       m_awaddr,
   input  logic [2*LenW-1:0]     m_awlen,
   input  logic [2*SizeW-1:0]    m_awsize,
   input  logic [2*BurstW-1:0]   m_awburst,
   input  logic [1:0]            m_awvalid,
   output logic [1:0]            m_awready,
   input  logic [2*DW-1:0]       m_wdata,
   input  logic [2*SW-1:0]       m_wstrb,
   input  logic [1:0]            m_wlast,
   input  logic [1:0]            m_wvalid,
   output logic [1:0]            m_wready,
   output logic [2*RespW-1:0]    m_bresp,
   output logic [1:0]            m_bvalid,
   input  logic [1:0]            m_bready,
   output logic [AW-1:0]         s_awaddr,
   output logic [LenW-1:0]       s_awlen,
   output logic [SizeW-1:0]      s_awsize,
   output logic [BurstW-1:0]     s_awburst,
   output logic                  s_awvalid,
   input  logic                  s_awready,
   output logic [DW-1:0]         s_wdata,
   output logic [SW-1:0]         s_wstrb,
   output logic                  s_wlast,
   output logic                  s_wvalid,
   input  logic                  s_wready,
   input  logic [RespW-1:0]      s_bresp,
   input  logic                  s_bvalid,
   output logic                  s_bready,
   output logic [1:0]            grant,
   output logic                  err_wlast
);

   arb_state_e        state_q, state_d;
   logic [1:0]        grant_q, grant_d;
   logic [LenW-1:0]   beat_q, beat_d;
   logic [LenW-1:0]   len_q, len_d;
   logic              rr_q, rr_d;
   logic              err_q, err_d;

   logic [1:0]        pick_gnt;
   logic              idx;
   logic              last_beat;
   logic              aw_hs, w_hs, b_hs;

   rr_arbiter2 u_rr (
      .req_i (m_awvalid),
      .ptr_i (rr_q),
      .gnt_o (pick_gnt)
   );

   // Grant is one-hot, so bit 1 doubles as the owner index.
   assign idx       = grant_q[1];
   assign last_beat = (beat_q == len_q);
   assign aw_hs     = s_awvalid && s_awready;
   assign w_hs      = s_wvalid && s_wready;
   assign b_hs      = s_bvalid && s_bready;
   assign grant     = grant_q;
   assign err_wlast = err_q;

   always_comb begin
      s_awaddr  = '0;
      s_awlen   = '0;
      s_awsize  = '0;
      s_awburst = '0;
      s_awvalid = 1'b0;
      s_wdata   = '0;
      s_wstrb   = '0;
      s_wlast   = 1'b0;
      s_wvalid  = 1'b0;
      s_bready  = 1'b0;
      m_awready = 2'b00;
      m_wready  = 2'b00;
      m_bvalid  = 2'b00;
      m_bresp   = '0;
      case (state_q)
         StAddr: begin
            s_awaddr  = idx ? m_awaddr[2*AW-1:AW] : m_awaddr[AW-1:0];
            s_awlen   = idx ? m_awlen[2*LenW-1:LenW] : m_awlen[LenW-1:0];
            s_awsize  = idx ? m_awsize[2*SizeW-1:SizeW] : m_awsize[SizeW-1:0];
            s_awburst = idx ? m_awburst[2*BurstW-1:BurstW] : m_awburst[BurstW-1:0];
            s_awvalid = m_awvalid[idx];
            m_awready = grant_q & {2{s_awready}};
         end
         StData: begin
            s_wdata  = idx ? m_wdata[2*DW-1:DW] : m_wdata[DW-1:0];
            s_wstrb  = idx ? m_wstrb[2*SW-1:SW] : m_wstrb[SW-1:0];
            s_wvalid = m_wvalid[idx];
            s_wlast  = last_beat;
            m_wready = grant_q & {2{s_wready}};
         end
         StResp: begin
            s_bready = m_bready[idx];
            m_bvalid = grant_q & {2{s_bvalid}};
            if (idx) begin
               m_bresp[2*RespW-1:RespW] = s_bresp;
            end else begin
               m_bresp[RespW-1:0] = s_bresp;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      beat_d  = beat_q;
      len_d   = len_q;
      rr_d    = rr_q;
      err_d   = err_q;
      case (state_q)
         StIdle: begin
            if (|m_awvalid) begin
               grant_d = pick_gnt;
               state_d = StAddr;
            end
         end
         StAddr: begin
            if (aw_hs) begin
               len_d   = s_awlen;
               beat_d  = '0;
               state_d = StData;
            end
         end
         StData: begin
            if (w_hs) begin
               if (m_wlast[idx] != s_wlast) begin
                  err_d = 1'b1;
               end
               // Hold the counter on the final beat so len=255 never wraps.
               if (last_beat) begin
                  state_d = StResp;
               end else begin
                  beat_d = beat_q + 8'd1;
               end
            end
         end
         StResp: begin
            if (b_hs) begin
               rr_d    = ~idx;
               grant_d = 2'b00;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         grant_q <= 2'b00;
         beat_q  <= '0;
         len_q   <= '0;
         rr_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         beat_q  <= beat_d;
         len_q   <= len_d;
         rr_q    <= rr_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Scoreboard bench for axi_write_arbiter: expected AW/W/B traffic is queued in grant order.
module tb_axi_write_arbiter;
   import axi_arb_pkg::*;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 64;
   localparam int unsigned SW = 8;
   localparam int Budget = 1000;

   logic            clk, resetn;
   logic [2*AW-1:0] m_awaddr;
   logic [15:0]     m_awlen;
   logic [5:0]      m_awsize;
   logic [3:0]      m_awburst;
   logic [1:0]      m_awvalid, m_awready;
   logic [2*DW-1:0] m_wdata;
   logic [2*SW-1:0] m_wstrb;
   logic [1:0]      m_wlast, m_wvalid, m_wready;
   logic [3:0]      m_bresp;
   logic [1:0]      m_bvalid, m_bready;
   logic [AW-1:0]   s_awaddr;
   logic [7:0]      s_awlen;
   logic [2:0]      s_awsize;
   logic [1:0]      s_awburst;
   logic            s_awvalid, s_awready;
   logic [DW-1:0]   s_wdata;
   logic [SW-1:0]   s_wstrb;
   logic            s_wlast, s_wvalid, s_wready;
   logic [1:0]      s_bresp;
   logic            s_bvalid, s_bready;
   logic [1:0]      grant;
   logic            err_wlast;

   typedef struct packed {logic [1:0] gnt; logic [31:0] addr; logic [7:0] len;} aw_exp_t;
   typedef struct packed {logic [1:0] gnt; logic [63:0] data; logic [7:0] strb; logic last;} w_exp_t;
   typedef struct packed {logic [1:0] gnt; logic [1:0] resp;} b_exp_t;

   aw_exp_t aw_q[$];
   w_exp_t  w_q[$];
   b_exp_t  b_q[$];
   aw_exp_t e_aw;
   w_exp_t  e_w;
   b_exp_t  e_b;

   int total = 0;
   int bad = 0;
   int viol = 0;
   int w_cnt = 0;
   int c0;
   logic [1:0] slv_resp;
   logic       tog_wready;

   axi_write_arbiter #(.AW(AW), .DW(DW), .SW(SW)) dut (
      .clk(clk), .resetn(resetn),
      .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
      .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
      .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
      .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
      .s_wready(s_wready), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .grant(grant), .err_wlast(err_wlast)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] wdat(input logic [31:0] a, input int b);
      return {a, 24'h0, b[7:0]};
   endfunction

   function automatic logic [7:0] wstb(input int b);
      return ~b[7:0];
   endfunction

   task automatic plan(input int i, input logic [31:0] a, input int len, input logic [1:0] resp);
      logic [1:0] g;
      g = (i == 0) ? 2'b01 : 2'b10;
      aw_q.push_back('{gnt: g, addr: a, len: len[7:0]});
      for (int b = 0; b <= len; b++) begin
         w_q.push_back('{gnt: g, data: wdat(a, b), strb: wstb(b), last: (b == len)});
      end
      b_q.push_back('{gnt: g, resp: resp});
   endtask

   // ch: 0 awready, 1 wready, 2 bvalid. ok=0 on reset abort or timeout.
   task automatic await_sig(input int i, input int ch, output bit ok);
      logic s;
      ok = 1'b0;
      for (int n = 0; n < Budget; n++) begin
         @(negedge clk);
         if (!resetn) return;
         s = (ch == 0) ? m_awready[i] : (ch == 1) ? m_wready[i] : m_bvalid[i];
         if (s) begin
            ok = 1'b1;
            return;
         end
      end
      total++;
      bad++;
      $display("FAIL handshake_timeout: got none required ch%0d on requester %0d", ch, i);
   endtask

   task automatic drive_beat(input int i, input logic [31:0] a, input int b, input int len,
                             input int bad_beat);
      m_wdata[i*DW +: DW] = wdat(a, b);
      m_wstrb[i*SW +: SW] = wstb(b);
      m_wlast[i]          = (b == len) != (b == bad_beat);
      m_wvalid[i]         = 1'b1;
   endtask

   // First W beat is presented together with AW; it must wait for the address handshake.
   task automatic master(input int i, input logic [31:0] a, input int len, input int bad_beat);
      bit ok;
      m_awaddr[i*AW +: AW] = a;
      m_awlen[i*8 +: 8]    = len[7:0];
      m_awsize[i*3 +: 3]   = 3'd3;
      m_awburst[i*2 +: 2]  = 2'd1;
      m_awvalid[i]         = 1'b1;
      drive_beat(i, a, 0, len, bad_beat);
      await_sig(i, 0, ok);
      if (!ok) begin
         m_awvalid[i] = 1'b0;
         m_wvalid[i]  = 1'b0;
         return;
      end
      @(posedge clk);
      #1 m_awvalid[i] = 1'b0;
      for (int b = 0; b <= len; b++) begin
         drive_beat(i, a, b, len, bad_beat);
         await_sig(i, 1, ok);
         if (!ok) begin
            m_wvalid[i] = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      m_wvalid[i] = 1'b0;
      m_wlast[i]  = 1'b0;
      m_bready[i] = 1'b1;
      await_sig(i, 2, ok);
      if (ok) @(posedge clk);
      #1 m_bready[i] = 1'b0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Slave model: always accepts AW, optionally toggles WREADY, answers B after the last beat.
   initial begin
      logic wl, bh;
      s_awready = 1'b1;
      s_wready  = 1'b1;
      s_bvalid  = 1'b0;
      s_bresp   = 2'b00;
      forever begin
         @(negedge clk);
         wl = s_wvalid && s_wready && s_wlast;
         bh = s_bvalid && s_bready;
         @(posedge clk);
         #1;
         if (!resetn) begin
            s_bvalid = 1'b0;
            s_bresp  = 2'b00;
         end else begin
            if (bh) s_bvalid = 1'b0;
            if (wl) begin
               s_bvalid = 1'b1;
               s_bresp  = slv_resp;
            end
         end
         s_wready = tog_wready ? ~s_wready : 1'b1;
      end
   end

   // Monitor: pops the scoreboard on every handshake the DUT presents.
   always @(negedge clk) begin
      if (resetn) begin
         if (s_awvalid && s_awready) begin
            if (aw_q.size() == 0) begin
               chk("aw_unexpected", 128'(s_awaddr), 128'(0));
            end else begin
               e_aw = aw_q.pop_front();
               chk("aw_addr", 128'(s_awaddr), 128'(e_aw.addr));
               chk("aw_len", 128'(s_awlen), 128'(e_aw.len));
               chk("aw_grant", 128'(grant), 128'(e_aw.gnt));
               chk("aw_size_burst", 128'({s_awsize, s_awburst}), 128'({3'd3, 2'd1}));
            end
         end
         if (s_wvalid && s_wready) begin
            w_cnt++;
            if (w_q.size() == 0) begin
               chk("w_unexpected", 128'(s_wdata), 128'(0));
            end else begin
               e_w = w_q.pop_front();
               chk("w_data", 128'(s_wdata), 128'(e_w.data));
               chk("w_strb", 128'(s_wstrb), 128'(e_w.strb));
               chk("w_last", 128'(s_wlast), 128'(e_w.last));
               chk("w_grant", 128'(grant), 128'(e_w.gnt));
            end
         end
         for (int i = 0; i < 2; i++) begin
            if (m_bvalid[i] && m_bready[i]) begin
               if (b_q.size() == 0) begin
                  chk("b_unexpected", 128'(i), 128'(2));
               end else begin
                  e_b = b_q.pop_front();
                  chk("b_owner", 128'(i == 0 ? 2'b01 : 2'b10), 128'(e_b.gnt));
                  chk("b_resp", 128'(m_bresp[i*2 +: 2]), 128'(e_b.resp));
               end
            end
            if (!grant[i] && (m_awready[i] || m_wready[i] || m_bvalid[i])) viol++;
            if (m_wready[i] && m_awvalid[i]) viol++;
         end
      end
   end

   initial begin
      resetn = 1'b0;
      m_awaddr = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0; m_awvalid = '0;
      m_wdata = '0; m_wstrb = '0; m_wlast = '0; m_wvalid = '0; m_bready = '0;
      slv_resp = RespOkay;
      tog_wready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_grant", 128'(grant), 128'(0));
      chk("rst_err", 128'(err_wlast), 128'(0));
      chk("rst_ctrl", 128'({s_awvalid, s_wvalid, s_wlast, s_bready, m_awready, m_wready,
                            m_bvalid, m_bresp}), 128'(0));
      resetn = 1'b1;
      @(posedge clk);
      #1;

      // Single requester 0, 4 beats; AW reaches the slave one cycle after awvalid.
      c0 = w_cnt;
      plan(0, 32'h1000, 3, RespOkay);
      fork
         master(0, 32'h1000, 3, -1);
         begin
            @(negedge clk);
            chk("lat_idle_awvalid", 128'(s_awvalid), 128'(0));
            @(negedge clk);
            chk("lat_addr_awvalid", 128'(s_awvalid), 128'(1));
            chk("lat_addr_grant", 128'(grant), 128'(2'b01));
         end
      join
      chk("t1_beats", 128'(w_cnt - c0), 128'(4));
      chk("t1_grant_released", 128'(grant), 128'(0));

      // Simultaneous requests after reset: requester 0 first.
      do_reset();
      plan(0, 32'h2000, 1, RespOkay);
      plan(1, 32'h3000, 2, RespOkay);
      fork
         master(0, 32'h2000, 1, -1);
         master(1, 32'h3000, 2, -1);
      join
      chk("t2_grant_released", 128'(grant), 128'(0));

      // Back-to-back from both: grants alternate 01,10,01,10.
      slv_resp = RespSlverr;
      plan(0, 32'h4000, 1, RespSlverr);
      plan(1, 32'h4100, 2, RespSlverr);
      plan(0, 32'h4200, 0, RespSlverr);
      plan(1, 32'h4300, 1, RespSlverr);
      fork
         begin
            master(0, 32'h4000, 1, -1);
            master(0, 32'h4200, 0, -1);
         end
         begin
            master(1, 32'h4100, 2, -1);
            master(1, 32'h4300, 1, -1);
         end
      join

      // Length boundaries with WREADY toggling.
      slv_resp = RespOkay;
      tog_wready = 1'b1;
      c0 = w_cnt;
      plan(0, 32'h5000, 0, RespOkay);
      master(0, 32'h5000, 0, -1);
      chk("len0_beats", 128'(w_cnt - c0), 128'(1));
      c0 = w_cnt;
      plan(0, 32'h6000, 255, RespOkay);
      master(0, 32'h6000, 255, -1);
      chk("len255_beats", 128'(w_cnt - c0), 128'(256));
      tog_wready = 1'b0;

      // Early WLAST from requester 1 on beat 2 sets the sticky error.
      chk("err_before", 128'(err_wlast), 128'(0));
      plan(1, 32'h7000, 3, RespOkay);
      master(1, 32'h7000, 3, 1);
      chk("err_set", 128'(err_wlast), 128'(1));
      plan(0, 32'h8000, 1, RespOkay);
      master(0, 32'h8000, 1, -1);
      chk("err_sticky", 128'(err_wlast), 128'(1));

      // Reset during beat 2: only AW and two beats ever reach the slave.
      aw_q.push_back('{gnt: 2'b01, addr: 32'h9000, len: 8'd3});
      for (int b = 0; b < 2; b++) begin
         w_q.push_back('{gnt: 2'b01, data: wdat(32'h9000, b), strb: wstb(b), last: 1'b0});
      end
      c0 = w_cnt;
      fork
         master(0, 32'h9000, 3, -1);
      join_none
      for (int n = 0; n < 200 && (w_cnt - c0) < 2; n++) begin
         @(negedge clk);
         #1;
      end
      chk("rst_mid_beats", 128'(w_cnt - c0), 128'(2));
      @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("rst_mid_grant", 128'(grant), 128'(0));
      chk("rst_mid_err", 128'(err_wlast), 128'(0));
      chk("rst_mid_ctrl", 128'({s_awvalid, s_wvalid, s_wlast, s_bready, m_awready, m_wready,
                                m_bvalid, m_bresp}), 128'(0));
      chk("rst_mid_data", 128'({s_wdata, s_wstrb, s_awaddr}), 128'(0));
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      @(posedge clk);
      #1;
      plan(1, 32'hA000, 2, RespOkay);
      master(1, 32'hA000, 2, -1);
      chk("post_rst_grant", 128'(grant), 128'(0));

      repeat (2) @(posedge clk);
      chk("aw_q_drained", 128'(aw_q.size()), 128'(0));
      chk("w_q_drained", 128'(w_q.size()), 128'(0));
      chk("b_q_drained", 128'(b_q.size()), 128'(0));
      chk("non_granted_quiet", 128'(viol), 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
